// File: rtl/lsu_if.sv
// Request/response and data-memory signal bundle for the load/store unit.
// The slave modport is the LSU's view; master is the execute stage plus memory.
interface lsu_if #(
  parameter int unsigned AW = 6
) ();
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;

  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;

  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: byte/half/word accesses onto a word-wide data memory, with
// read-modify-write for sub-word stores. Misalignment check: LSU_MISALIGN_CHK_EN.
module lsu #(
  parameter int unsigned AW = 6
) (
  input logic   clk,
  input logic   rst,
  lsu_if.slave  bus
);

  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MERGE,
    ST_WRITE,
    ST_RESP
  } state_t;

  state_t          r_state;
  logic [1:0]      r_lane;
  logic [1:0]      r_size;
  logic            r_unsigned;
  logic [15:0]     r_wdata;
  logic [DW-1:0]   r_merge;
  logic [AW-1:0]   r_mem_addr;
  logic            r_mem_rd;
  logic            r_mem_wr;
  logic            r_resp_valid;
  logic [DW-1:0]   r_resp_rdata;
  logic            r_resp_err;

  logic            w_hs;
  logic            w_misalign;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [DW-1:0]   w_load_data;
  logic [DW-1:0]   w_merge_data;

  assign bus.req_ready  = (r_state == ST_IDLE) && !rst;
  assign w_hs           = bus.req_valid && bus.req_ready;

  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_merge;
  // Strobes are masked by reset so a reset in the WRITE cycle cannot corrupt memory.
  assign bus.mem_rd     = r_mem_rd && !rst;
  assign bus.mem_wr     = r_mem_wr && !rst;

`ifdef LSU_MISALIGN_CHK_EN
  // Sizes 10 and 11 are both word accesses.
  assign w_misalign = (bus.req_size == 2'b01) ? bus.req_addr[0]
                    : (bus.req_size[1]      ? (bus.req_addr[1:0] != 2'b00) : 1'b0);
  assign bus.resp_err = r_resp_err;
`else
  assign w_misalign   = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  // Little-endian lane extraction and extension of the addressed word.
  always_comb begin
    w_byte      = 8'(bus.mem_rdata >> {r_lane, 3'b000});
    w_half      = 16'(bus.mem_rdata >> {r_lane[1], 4'b0000});
    w_load_data = bus.mem_rdata;
    case (r_size)
      2'b00:   w_load_data = r_unsigned ? {24'h000000, w_byte}
                                        : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_data = r_unsigned ? {16'h0000, w_half}
                                        : {{16{w_half[15]}}, w_half};
      default: w_load_data = bus.mem_rdata;
    endcase
  end

  // Replace the target lane(s) of the fetched word with the store data.
  always_comb begin
    w_merge_data = bus.mem_rdata;
    if (r_size == 2'b00) begin
      w_merge_data[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merge_data[{r_lane[1], 4'b0000} +: 16] = r_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_lane       <= 2'b00;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_wdata      <= 16'h0000;
      r_merge      <= '0;
      r_mem_addr   <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_lane     <= bus.req_addr[1:0];
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_wdata    <= bus.req_wdata[15:0];
            r_resp_err <= 1'b0;
            if (w_misalign) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else if (!bus.req_we) begin
              r_state    <= ST_LOAD;
              r_mem_addr <= bus.req_addr[AW+1:2];
            end else if (bus.req_size[1]) begin
              r_state    <= ST_WRITE;
              r_mem_addr <= bus.req_addr[AW+1:2];
              r_merge    <= bus.req_wdata;
              r_mem_rd   <= 1'b1;
              r_mem_wr   <= 1'b1;
            end else begin
              r_state    <= ST_MERGE;
              r_mem_addr <= bus.req_addr[AW+1:2];
            end
          end
        end
        ST_LOAD: begin
          r_state      <= ST_RESP;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_load_data;
        end
        ST_MERGE: begin
          r_state  <= ST_WRITE;
          r_merge  <= w_merge_data;
          r_mem_rd <= 1'b1;
          r_mem_wr <= 1'b1;
        end
        ST_WRITE: begin
          r_state      <= ST_RESP;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= '0;
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: word/sub-word stores and loads, extension, misalignment,
// reset during a store and the one-request-at-a-time handshake.
module tb_lsu;
  localparam int unsigned AW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_if #(.AW(AW)) bus ();
  lsu #(.AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Data memory: combinational read, write on posedge.
  logic [31:0] mem [0:(1<<AW)-1];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt, wr_cyc, rd_bad, busy_ready;
  logic [AW-1:0] wr_addr, first_addr;
  logic [31:0]   wr_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request at the current negedge, follow it to its response and
  // leave the bench in the cycle after RESP.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [7:0] addr, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_wr_cyc);
    int lat;
    logic [31:0] rd;
    logic er;
    lat = 0; rd = '0; er = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
    wr_cnt = 0; wr_cyc = 0; rd_bad = 0; busy_ready = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (c == 1) first_addr = bus.mem_addr;
      if (bus.mem_wr) begin
        wr_cnt++; wr_cyc = c; wr_addr = bus.mem_addr; wr_data = bus.mem_wdata;
        if (!bus.mem_rd) rd_bad++;
      end else if (bus.mem_rd) rd_bad++;
      if (bus.req_ready) busy_ready++;
      if (bus.resp_valid) begin
        lat = c; rd = bus.resp_rdata; er = bus.resp_err;
        break;
      end
    end
    chk({tag, ".lat"},    32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"},  rd, exp_rd);
    chk({tag, ".err"},    32'(er), 32'(exp_err));
    chk({tag, ".wrcnt"},  32'(wr_cnt), (exp_wr_cyc != 0) ? 32'd1 : 32'd0);
    chk({tag, ".wrcyc"},  32'(wr_cyc), 32'(exp_wr_cyc));
    chk({tag, ".rdstb"},  32'(rd_bad), 32'd0);
    chk({tag, ".busy"},   32'(busy_ready), 32'd0);
    @(negedge clk);
    chk({tag, ".pulse"},  32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    // Reset state
    @(negedge clk);
    chk("rst.ready",  32'(bus.req_ready),  32'd0);
    chk("rst.rvalid", 32'(bus.resp_valid), 32'd0);
    chk("rst.rdata",  bus.resp_rdata,      32'd0);
    chk("rst.err",    32'(bus.resp_err),   32'd0);
    chk("rst.maddr",  32'(bus.mem_addr),   32'd0);
    chk("rst.mrd",    32'(bus.mem_rd),     32'd0);
    chk("rst.mwr",    32'(bus.mem_wr),     32'd0);
    chk("rst.mwdata", bus.mem_wdata,       32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.ready1", 32'(bus.req_ready), 32'd1);

    // Word store then load
    do_req("sw10", 1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1);
    chk("sw10.waddr", 32'(wr_addr), 32'd4);
    chk("sw10.wdata", wr_data, 32'hDEADBEEF);
    do_req("lw10", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0);
    chk("lw10.maddr", 32'(first_addr), 32'd4);

    // Byte store read-modify-write
    do_req("sw0c", 1'b1, 2'b10, 1'b0, 8'h0C, 32'h11223344, 2, 32'h0, 1'b0, 1);
    do_req("sb0e", 1'b1, 2'b00, 1'b0, 8'h0E, 32'hFFFFFFAB, 3, 32'h0, 1'b0, 2);
    chk("sb0e.raddr", 32'(first_addr), 32'd3);
    chk("sb0e.waddr", 32'(wr_addr), 32'd3);
    chk("sb0e.wdata", wr_data, 32'h11AB3344);
    do_req("lw0c", 1'b0, 2'b10, 1'b0, 8'h0C, 32'h0, 2, 32'h11AB3344, 1'b0, 0);

    // Extension
    do_req("sw14", 1'b1, 2'b10, 1'b0, 8'h14, 32'h80FF7F01, 2, 32'h0, 1'b0, 1);
    do_req("lb15",  1'b0, 2'b00, 1'b0, 8'h15, 32'h0, 2, 32'h0000007F, 1'b0, 0);
    do_req("lb16",  1'b0, 2'b00, 1'b0, 8'h16, 32'h0, 2, 32'hFFFFFFFF, 1'b0, 0);
    do_req("lbu17", 1'b0, 2'b00, 1'b1, 8'h17, 32'h0, 2, 32'h00000080, 1'b0, 0);
    do_req("lh16",  1'b0, 2'b01, 1'b0, 8'h16, 32'h0, 2, 32'hFFFF80FF, 1'b0, 0);
    do_req("lhu16", 1'b0, 2'b01, 1'b1, 8'h16, 32'h0, 2, 32'h000080FF, 1'b0, 0);
    do_req("lb14",  1'b0, 2'b00, 1'b0, 8'h14, 32'h0, 2, 32'h00000001, 1'b0, 0);
    do_req("lh14",  1'b0, 2'b01, 1'b0, 8'h14, 32'h0, 2, 32'h00007F01, 1'b0, 0);
    do_req("lw14s3", 1'b0, 2'b11, 1'b0, 8'h14, 32'h0, 2, 32'h80FF7F01, 1'b0, 0);

    // Halfword store into the upper lane
    do_req("sh12", 1'b1, 2'b01, 1'b0, 8'h12, 32'h1234CAFE, 3, 32'h0, 1'b0, 2);
    chk("sh12.wdata", wr_data, 32'hCAFEBEEF);
    do_req("lw10b", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 2, 32'hCAFEBEEF, 1'b0, 0);

    // Misaligned accesses
    do_req("sw00", 1'b1, 2'b10, 1'b0, 8'h00, 32'h0BADF00D, 2, 32'h0, 1'b0, 1);
`ifdef LSU_MISALIGN_CHK_EN
    do_req("lw02", 1'b0, 2'b10, 1'b0, 8'h02, 32'h0, 1, 32'h0, 1'b1, 0);
    do_req("sh01", 1'b1, 2'b01, 1'b0, 8'h01, 32'h00005555, 1, 32'h0, 1'b1, 0);
    do_req("lw00", 1'b0, 2'b10, 1'b0, 8'h00, 32'h0, 2, 32'h0BADF00D, 1'b0, 0);
`else
    do_req("lw02", 1'b0, 2'b10, 1'b0, 8'h02, 32'h0, 2, 32'h0BADF00D, 1'b0, 0);
    do_req("sh01", 1'b1, 2'b01, 1'b0, 8'h01, 32'h00005555, 3, 32'h0, 1'b0, 2);
    chk("sh01.wdata", wr_data, 32'h0BAD5555);
    do_req("lw00", 1'b0, 2'b10, 1'b0, 8'h00, 32'h0, 2, 32'h0BAD5555, 1'b0, 0);
`endif

    // Reset during MERGE drops the store
    do_req("sw18", 1'b1, 2'b10, 1'b0, 8'h18, 32'h01020304, 2, 32'h0, 1'b0, 1);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 8'h19; bus.req_wdata = 32'h000000EE;
    chk("rstm.ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rstm.mwr1", 32'(bus.mem_wr), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstm.mwr2",   32'(bus.mem_wr),     32'd0);
    chk("rstm.rvalid", 32'(bus.resp_valid), 32'd0);
    chk("rstm.ready0", 32'(bus.req_ready),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstm.ready1", 32'(bus.req_ready),  32'd1);
    chk("rstm.rv3",    32'(bus.resp_valid), 32'd0);
    chk("rstm.mwr3",   32'(bus.mem_wr),     32'd0);
    do_req("lw18", 1'b0, 2'b10, 1'b0, 8'h18, 32'h0, 2, 32'h01020304, 1'b0, 0);

    // Reset during WRITE masks the write strobe
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
    bus.req_addr = 8'h18; bus.req_wdata = 32'h55AA55AA;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rstw.mwr1", 32'(bus.mem_wr), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw.mwr0", 32'(bus.mem_wr), 32'd0);
    chk("rstw.mrd0", 32'(bus.mem_rd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstw.rvalid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    do_req("lw18b", 1'b0, 2'b10, 1'b0, 8'h18, 32'h0, 2, 32'h01020304, 1'b0, 0);

    // Held req_valid with a second request queued behind the first
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 8'h10;
    chk("hs.ready_n", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_size = 2'b00; bus.req_unsigned = 1'b1; bus.req_addr = 8'h17;
    chk("hs.ready_n1", 32'(bus.req_ready),  32'd0);
    chk("hs.rv_n1",    32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    chk("hs.ready_n2", 32'(bus.req_ready),  32'd0);
    chk("hs.rv_n2",    32'(bus.resp_valid), 32'd1);
    chk("hs.rd_n2",    bus.resp_rdata,      32'hCAFEBEEF);
    @(negedge clk);
    chk("hs.ready_n3", 32'(bus.req_ready),  32'd1);
    chk("hs.rv_n3",    32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("hs.ready_n4", 32'(bus.req_ready),  32'd0);
    chk("hs.rv_n4",    32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    chk("hs.rv_n5",    32'(bus.resp_valid), 32'd1);
    chk("hs.rd_n5",    bus.resp_rdata,      32'h00000080);
    @(negedge clk);
    chk("hs.ready_n6", 32'(bus.req_ready),  32'd1);
    chk("hs.rv_n6",    32'(bus.resp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
